// File: rtl/candidate_select_pkg.sv
// -----------------------------------------------------------------------------
// candidate_pkg
// Shared definitions for the candidate search datapath: lane width, the
// result-collector state encoding and the cost-width derivation that the
// candidate generator also relies on.
// -----------------------------------------------------------------------------
package candidate_pkg;

    // Width of one fixed-point lane in a candidate row.
    localparam int LANE_W = 64;

    // Result-collector states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Cost width: one lane plus enough headroom that a full-row sum never wraps.
    function automatic int calc_sumw(input int lanes);
        return LANE_W + $clog2(lanes);
    endfunction

endpackage

// File: rtl/candidate_select_if.sv
// -----------------------------------------------------------------------------
// candidate_select_if
// Row stream (generator -> selector) plus result port (selector -> controller).
//   master : driven by generator/controller side (rows, J_index, result_ready)
//   slave  : driven by candidate_select (tready, best_index, best_cost,
//            result_valid)
// -----------------------------------------------------------------------------
interface candidate_select_if
    import candidate_pkg::*;
#(
    parameter int J     = 14,
    parameter int CNT_W = 16
) ();
    localparam int J_WIDTH = $clog2(J) + 1;
    localparam int SUMW    = calc_sumw(J);

    logic [J_WIDTH-1:0]       J_index;
    logic [J*LANE_W-1:0]      candidate_row;
    logic                     candidate_row_tvalid;
    logic                     candidate_row_tlast;
    logic                     candidate_row_tready;
    logic [CNT_W-1:0]         best_index;
    logic signed [SUMW-1:0]   best_cost;
    logic                     result_valid;
    logic                     result_ready;

    modport master (
        output J_index, candidate_row, candidate_row_tvalid, candidate_row_tlast,
        output result_ready,
        input  candidate_row_tready, best_index, best_cost, result_valid
    );

    modport slave (
        input  J_index, candidate_row, candidate_row_tvalid, candidate_row_tlast,
        input  result_ready,
        output candidate_row_tready, best_index, best_cost, result_valid
    );
endinterface

// File: rtl/candidate_select_row_cost.sv
// -----------------------------------------------------------------------------
// row_cost
// Masked, sign-extending sum of the first min(lim_i, J) lanes of a row,
// registered (pipeline stage 1).
//   clk, rst  : clock, synchronous active-high reset
//   en_i      : row accepted this cycle
//   last_i    : accepted row is the last of its frame
//   row_i     : J lanes of LANE_W bits, lane 0 at the LSB
//   lim_i     : active lane count (clamped to J here)
//   sum_o     : registered cost
//   valid_o   : sum_o holds a freshly accepted row
//   last_o    : that row was the frame's last
// -----------------------------------------------------------------------------
module row_cost
    import candidate_pkg::*;
#(
    parameter int J       = 14,
    parameter int J_WIDTH = $clog2(J) + 1,
    parameter int SUMW    = calc_sumw(J)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   last_i,
    input  logic [J*LANE_W-1:0]    row_i,
    input  logic [J_WIDTH-1:0]     lim_i,
    output logic signed [SUMW-1:0] sum_o,
    output logic                   valid_o,
    output logic                   last_o
);
    // Sign-extend one lane to the cost width.
    function automatic logic signed [SUMW-1:0] sext_lane(input logic [LANE_W-1:0] lane);
        return {{(SUMW-LANE_W){lane[LANE_W-1]}}, lane};
    endfunction

    logic [J_WIDTH-1:0]     lim_s;
    logic signed [SUMW-1:0] sum_d;
    logic signed [SUMW-1:0] sum_q;
    logic                   valid_q;
    logic                   last_q;

    // Clamp the lane limit and accumulate only lanes below it.
    always_comb begin
        lim_s = (lim_i > J_WIDTH'(J)) ? J_WIDTH'(J) : lim_i;
        sum_d = '0;
        for (int k = 0; k < J; k++) begin
            if (J_WIDTH'(k) < lim_s) begin
                sum_d = sum_d + sext_lane(row_i[k*LANE_W +: LANE_W]);
            end else begin
                sum_d = sum_d;
            end
        end
    end

    // Stage-1 register: capture the cost of each accepted row.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= en_i;
            if (en_i) begin
                sum_q  <= sum_d;
                last_q <= last_i;
            end
        end
    end

    assign sum_o   = sum_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
endmodule

// File: rtl/candidate_select.sv
// -----------------------------------------------------------------------------
// candidate_select
// Consumes one frame of candidate rows, tracks the minimum-cost row and hands
// the winner (index, cost) to the search controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of candidate_select_if (row stream in, result out)
// -----------------------------------------------------------------------------
module candidate_select
    import candidate_pkg::*;
#(
    parameter int J     = 14,
    parameter int CNT_W = 16,
    localparam int J_WIDTH = $clog2(J) + 1,
    localparam int SUMW    = calc_sumw(J)
) (
    input  logic               clk,
    input  logic               rst,
    candidate_select_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_HOLD  = HOLD;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]             state_q, state_d;
    logic                   tready_s, accept_s;
    logic [J_WIDTH-1:0]     j_lat_q, j_sel_s;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       best_idx_q;
    logic signed [SUMW-1:0] best_cost_q;
    logic                   best_vld_q;
    logic                   result_valid_q;
    logic signed [SUMW-1:0] s1_sum_s;
    logic                   s1_valid_s, s1_last_s;

    // Ready only in the accepting states, and never while reset is asserted.
    assign tready_s = !rst && ((state_q == S_IDLE) || (state_q == S_RUN));
    assign accept_s = bus.candidate_row_tvalid && tready_s;
    // The first beat uses the live J_index; later beats use the latched copy.
    assign j_sel_s  = (state_q == S_IDLE) ? bus.J_index : j_lat_q;

    row_cost #(.J(J), .J_WIDTH(J_WIDTH), .SUMW(SUMW)) u_row_cost (
        .clk     (clk),
        .rst     (rst),
        .en_i    (accept_s),
        .last_i  (bus.candidate_row_tlast),
        .row_i   (bus.candidate_row),
        .lim_i   (j_sel_s),
        .sum_o   (s1_sum_s),
        .valid_o (s1_valid_s),
        .last_o  (s1_last_s)
    );

    // Frame FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = bus.candidate_row_tlast ? S_DRAIN : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept_s && bus.candidate_row_tlast) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            // The last row reaches stage 2 on this edge; result is then final.
            S_DRAIN: begin
                if (s1_valid_s && s1_last_s) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (bus.result_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage 2: FSM, J_index latch, row counter and best-row tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            j_lat_q        <= '0;
            cnt_q          <= '0;
            best_idx_q     <= '0;
            best_cost_q    <= '0;
            best_vld_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            result_valid_q <= (state_d == S_HOLD);
            if (accept_s && (state_q == S_IDLE)) begin
                j_lat_q <= bus.J_index;
            end
            if (s1_valid_s) begin
                // Strict less-than keeps the earliest row on a tie.
                if (!best_vld_q || (s1_sum_s < best_cost_q)) begin
                    best_idx_q  <= cnt_q;
                    best_cost_q <= s1_sum_s;
                end
                best_vld_q <= 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else if ((state_q == S_HOLD) && bus.result_ready) begin
                // Result consumed: clear bookkeeping for the next frame.
                cnt_q       <= '0;
                best_idx_q  <= '0;
                best_cost_q <= '0;
                best_vld_q  <= 1'b0;
            end
        end
    end

    assign bus.candidate_row_tready = tready_s;
    assign bus.best_index           = best_idx_q;
    assign bus.best_cost            = best_cost_q;
    assign bus.result_valid         = result_valid_q;
endmodule
